seg7_scan_driver: RTL and testbench

- Parametrised successor to the team's 3-digit score display decoder.
- Accepts an unsigned binary value on a load strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives DIGITS multiplexed 7-segment digits with a programmable scan rate, leading-zero blanking, per-digit decimal points, overflow indication and configurable pin polarity.
- Sits between the game/score logic and the board 7-seg pins.

---
 rtl/seg7_scan_driver.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (double-dabble, VALUE_W cycles, load ignored while busy) driving DIGITS multiplexed 7-seg digits.
// Optional blink gating of the outputs is enabled with `define SEG7_BLINK_EN.
module seg7_scan_driver #(
    parameter int DIGITS         = 3,
    parameter int VALUE_W        = 11,
    parameter int SCAN_DIV       = 10000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0,
    parameter int BLINK_DIV      = 2500000
) (
    input  logic               CLOCK10M,
    input  logic               RESET_N,
`ifdef SEG7_BLINK_EN
    input  logic               blink,
`endif
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic [DIGITS-1:0]  dp,
    output logic               busy,
    output logic               overflow,
    output logic [7:0]         seg,
    output logic [DIGITS-1:0]  dig_sel
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          PS_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int          CNT_W   = $clog2(VALUE_W + 1);
    localparam int          BCD_W   = 4 * DIGITS;
    localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);

    if (DIGITS < 1 || DIGITS > 8 || VALUE_W < 4 || VALUE_W > 27 || SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
        $error("seg7_scan_driver: parameter out of range");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [VALUE_W-1:0] cap;
    logic [BCD_W-1:0]   work, work_adj, work_next;
    logic [DIGITS-1:0]  dp_cap;
    logic               ovf_pend;
    logic [BCD_W-1:0]   disp_bcd;
    logic [DIGITS-1:0]  disp_dp;
    logic [PS_W-1:0]    prescale;
    logic [IDX_W-1:0]   scan_idx;
    logic               dark;

    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        work_next = {work_adj[BCD_W-2:0], cap[VALUE_W-1]};
    end

    // Display registers are only written on the final iteration, so the scan never sees a partial result.
    always_ff @(posedge CLOCK10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            ovf_pend <= 1'b0;
            cnt      <= '0;
            cap      <= '0;
            work     <= '0;
            dp_cap   <= '0;
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        cap      <= value;
                        dp_cap   <= dp;
                        ovf_pend <= ({{(32-VALUE_W){1'b0}}, value} > MAX_VAL);
                        work     <= '0;
                        cnt      <= CNT_W'(VALUE_W);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cap  <= cap << 1;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        disp_bcd <= work_next;
                        disp_dp  <= dp_cap;
                        overflow <= ovf_pend;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK10M or negedge RESET_N) begin
        if (!RESET_N) begin
            prescale <= '0;
            scan_idx <= '0;
        end else if (prescale == PS_W'(SCAN_DIV - 1)) begin
            prescale <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BL_W-1:0] bl_cnt;
    logic            bl_off;

    always_ff @(posedge CLOCK10M or negedge RESET_N) begin
        if (!RESET_N) begin
            bl_cnt <= '0;
            bl_off <= 1'b0;
        end else if (bl_cnt == BL_W'(BLINK_DIV - 1)) begin
            bl_cnt <= '0;
            bl_off <= ~bl_off;
        end else begin
            bl_cnt <= bl_cnt + 1'b1;
        end
    end

    assign dark = blink & bl_off;
`else
    assign dark = 1'b0;
`endif

    logic              lz;
    logic [DIGITS-1:0] blank;
    logic [3:0]        cur_nib;
    logic              cur_blank, cur_dp;
    logic [6:0]        seg7;
    logic [7:0]        seg_hi;
    logic [DIGITS-1:0] sel_hi;

    always_comb begin
        lz    = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz       = lz && (disp_bcd[4*i +: 4] == 4'd0);
            blank[i] = lz && (i != 0);
        end
        cur_nib   = disp_bcd[3:0];
        cur_blank = blank[0];
        cur_dp    = disp_dp[0];
        for (int i = 1; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_nib   = disp_bcd[4*i +: 4];
                cur_blank = blank[i];
                cur_dp    = disp_dp[i];
            end
        end
        case (cur_nib)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
        if (overflow)       seg7 = 7'b1000000;
        else if (cur_blank) seg7 = 7'b0000000;
        seg_hi = {cur_dp, seg7};
        sel_hi = DIGITS'(1) << scan_idx;
        if (dark) begin
            seg_hi = '0;
            sel_hi = '0;
        end
        seg     = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        dig_sel = (DIG_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (DIGITS=3, VALUE_W=11, SCAN_DIV=4) against an arithmetic display model.
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] value;
    logic        load;
    logic [2:0]  dp;
    logic        busy, overflow;
    logic [7:0]  seg;
    logic [2:0]  dig_sel;

    int checks = 0;
    int passes = 0;
    int cyc;
    int m_val = 0;
    logic [2:0] m_dp = '0;

    seg7_scan_driver #(.DIGITS(3), .VALUE_W(11), .SCAN_DIV(SD)) dut (
        .CLOCK10M(clk), .RESET_N(rst_n), .value(value), .load(load), .dp(dp),
        .busy(busy), .overflow(overflow), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the expected selected digit follows from this alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [7:0] exp_seg(input int v, input logic [2:0] dpv, input int d);
        int p, digit;
        logic [6:0] pat;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        digit = (v / p) % 10;
        case (digit)
            0: pat = 7'b0111111;  1: pat = 7'b0000110;  2: pat = 7'b1011011;
            3: pat = 7'b1001111;  4: pat = 7'b1100110;  5: pat = 7'b1101101;
            6: pat = 7'b1111101;  7: pat = 7'b0000111;  8: pat = 7'b1111111;
            default: pat = 7'b1101111;
        endcase
        if (v > 999)              pat = 7'b1000000;
        else if (d > 0 && v < p)  pat = 7'b0000000;
        return ~{dpv[d], pat};
    endfunction

    function automatic logic [2:0] exp_sel(input int c);
        logic [2:0] r;
        r = '0;
        r[(c / SD) % ND] = 1'b1;
        return r;
    endfunction

    task automatic drive_load(input int v, input logic [2:0] d);
        value = 11'(v);
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load = 1'b0; value = '0; dp = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passes++;
        for (int k = 0; k < 13; k++) begin
            checks++;
            if (dig_sel !== exp_sel(cyc)) $display("FAIL reset_sel cyc=%0d got %b want %b", cyc, dig_sel, exp_sel(cyc)); else passes++;
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL reset_seg cyc=%0d got %b want %b", cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_basic;
        int n;
        drive_load(407, 3'b000);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL basic_hold got %b want %b", seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
        checks++; if (n != 11) $display("FAIL basic_busy_len got %0d want 11", n); else passes++;
        m_val = 407; m_dp = 3'b000;
        checks++; if (overflow !== 1'b0) $display("FAIL basic_ovf got %b want 0", overflow); else passes++;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL basic_seg cyc=%0d got %b want %b", cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_load;
        int n;
        drive_load(5, 3'b000);
        repeat (2) @(negedge clk);
        drive_load(999, 3'b111);
        wait_busy(n);
        checks++; if (n != 8) $display("FAIL ignored_busy_len got %0d want 8", n); else passes++;
        m_val = 5; m_dp = 3'b000;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL ignored_seg cyc=%0d got %b want %b", cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_commit_edge;
        int n;
        drive_load(321, 3'b010);
        repeat (10) @(negedge clk);
        drive_load(777, 3'b000);
        checks++; if (busy !== 1'b0) $display("FAIL commit_edge_busy got %b want 0", busy); else passes++;
        m_val = 321; m_dp = 3'b010;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL commit_edge_seg cyc=%0d got %b want %b", cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
        drive_load(777, 3'b101);
        checks++; if (busy !== 1'b1) $display("FAIL reload_busy got %b want 1", busy); else passes++;
        wait_busy(n);
        checks++; if (n != 11) $display("FAIL reload_busy_len got %0d want 11", n); else passes++;
        m_val = 777; m_dp = 3'b101;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL reload_seg cyc=%0d got %b want %b", cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_overflow;
        int n;
        drive_load(1234, 3'b000);
        wait_busy(n);
        m_val = 1234; m_dp = 3'b000;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else passes++;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (seg !== 8'b10111111) $display("FAIL ovf_dash cyc=%0d got %b want 10111111", cyc, seg); else passes++;
            @(negedge clk);
        end
        drive_load(12, 3'b100);
        wait_busy(n);
        m_val = 12; m_dp = 3'b100;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passes++;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL ovf_after_seg cyc=%0d got %b want %b", cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        drive_load(1500, 3'b000);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL rstmid_ovf got %b want 0", overflow); else passes++;
        checks++; if (seg !== 8'b11000000) $display("FAIL rstmid_seg got %b want 11000000", seg); else passes++;
        checks++; if (dig_sel !== 3'b001) $display("FAIL rstmid_sel got %b want 001", dig_sel); else passes++;
        m_val = 0; m_dp = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        drive_load(86, 3'b001);
        wait_busy(n);
        checks++; if (n != 11) $display("FAIL rstmid_busy_len got %0d want 11", n); else passes++;
        m_val = 86; m_dp = 3'b001;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (dig_sel !== exp_sel(cyc)) $display("FAIL rstmid_scan_sel cyc=%0d got %b want %b", cyc, dig_sel, exp_sel(cyc)); else passes++;
            checks++;
            if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL rstmid_seg2 cyc=%0d got %b want %b", cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        int n, v;
        logic [2:0] d;
        for (int t = 0; t < 20; t++) begin
            v = int'($urandom_range(0, 2047));
            d = 3'($urandom_range(0, 7));
            drive_load(v, d);
            wait_busy(n);
            checks++; if (n != 11) $display("FAIL rand_busy_len v=%0d got %0d want 11", v, n); else passes++;
            m_val = v; m_dp = d;
            checks++; if (overflow !== (v > 999)) $display("FAIL rand_ovf v=%0d got %b want %b", v, overflow, (v > 999)); else passes++;
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (dig_sel !== exp_sel(cyc)) $display("FAIL rand_sel cyc=%0d got %b want %b", cyc, dig_sel, exp_sel(cyc)); else passes++;
                checks++;
                if (seg !== exp_seg(m_val, m_dp, (cyc / SD) % ND)) $display("FAIL rand_seg v=%0d cyc=%0d got %b want %b", v, cyc, seg, exp_seg(m_val, m_dp, (cyc / SD) % ND)); else passes++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_load();
        test_commit_edge();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
